// File: rtl/adder_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encoding
// and a helper that sizes digit counters.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } adder_state_e;

  // A counter over ndig digits needs at least one bit, even when ndig == 1.
  function automatic int unsigned ctr_width(input int unsigned ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/digit_add_slice.sv
// Combinational DIGIT-bit ripple adder. Also exposes the carry into the top
// bit so the caller can form signed overflow on the most significant digit.
module digit_add_slice #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             c_o,
  output logic             c_msb_o
);

  logic [DIGIT:0] carry;

  // Bit-by-bit ripple through the digit.
  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = c_i;
    for (int i = 0; i < DIGIT; i++) begin
      sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o     = carry[DIGIT];
  assign c_msb_o = carry[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock over WIDTH/DIGIT
// cycles, then presents sum, carry-out and signed overflow with a done pulse.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting; ready=1, start captures operands
// ST_RUN  | one digit added per cycle, low digit first
// ST_DONE | result just loaded; done=1, start may chain the next add
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = ctr_width(NDIG);
  localparam logic [CW-1:0] K_LAST = CW'(NDIG - 1);

  adder_state_e     state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] slice_sum;
  logic             slice_c;
  logic             slice_cmsb;
  logic [WIDTH-1:0] acc_shift;

  // Operands are shifted right each RUN cycle, so the slice always sees the
  // current digit in the low bits and no variable indexing is needed.
  digit_add_slice #(.DIGIT(DIGIT)) u_slice (
    .a_i     (a_q[DIGIT-1:0]),
    .b_i     (b_q[DIGIT-1:0]),
    .c_i     (c_q),
    .sum_o   (slice_sum),
    .c_o     (slice_c),
    .c_msb_o (slice_cmsb)
  );

  // New digit enters at the top; after NDIG shifts the result is aligned.
  if (NDIG == 1) begin : g_acc_single
    assign acc_shift = slice_sum;
  end else begin : g_acc_multi
    assign acc_shift = {slice_sum, acc_q[WIDTH-1:DIGIT]};
  end

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    k_d     = k_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub ? 1'b1 : cin;
          k_d     = '0;
          acc_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        c_d   = slice_c;
        acc_d = acc_shift;
        k_d   = k_q + 1'b1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          sum_d   = acc_shift;
          cout_d  = slice_c;
          ovf_d   = slice_c ^ slice_cmsb;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d != ST_RUN);
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      k_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule
